// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit loads/stores as two 16-bit async-SRAM accesses, freezing the pipeline via ready
// Ports: clk/rst (sync, active-high); MEM_R_EN/MEM_W_EN/address/writeData from EX/MEM;
// readData registered load result; ready=0 freezes the pipeline; SRAM_* drive the external SRAM.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] off;
  logic last, req, load, wr;
  assign req  = MEM_R_EN | MEM_W_EN;
  assign load = MEM_R_EN & ~MEM_W_EN;
  assign last = cnt_q == 4'(WAIT_CYCLES - 1);
  assign off  = address - 32'(BASE_ADDR);
  always_comb begin
    state_d = state_q == IDLE ? (req ? LO : IDLE) :
              state_q == LO   ? (last ? HI : LO) :
              state_q == HI   ? (last ? DONE : HI) : IDLE;
    // the counter only runs while dwelling in LO or HI
    cnt_d = (state_d != state_q || state_q == IDLE || state_q == DONE) ? 4'd0 : cnt_q + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      readData <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load && last && state_q == LO) readData[15:0]  <= SRAM_DQ;
      if (load && last && state_q == HI) readData[31:16] <= SRAM_DQ;
    end
  end
  assign wr        = MEM_W_EN && (state_q == LO || state_q == HI);
  assign SRAM_WE_N = ~wr;
  assign SRAM_DQ   = wr ? (state_q == HI ? writeData[31:16] : writeData[15:0]) : 16'hzzzz;
  assign SRAM_ADDR = {off[18:2], state_q == HI};
  assign ready     = (state_q == IDLE && !req) || state_q == DONE;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scoreboard bench with an SRAM model and a word-level reference memory
module tb_sram_controller;
  localparam int W = 2;
  typedef struct {
    bit          store;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [31:0] rd;
  } exp_t;
  logic clk = 0, rst = 1, mem_r_en = 0, mem_w_en = 0;
  logic [31:0] address = 32'd1024, write_data = 0, read_data;
  logic ready, sram_we_n, ub_n, lb_n, ce_n, oe_n;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic [15:0] mem [0:262143];
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd = 0;
  exp_t sb[$];
  exp_t cur;
  int vectors = 0, errs = 0, low = 0, we_cnt = 0;
  bit half;
  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .address(address), .writeData(write_data), .readData(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );
  always #5 clk = ~clk;
  assign sram_dq = (mem_r_en && !mem_w_en && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!sram_we_n && !rst) mem[sram_addr] <= sram_dq;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] o;
    o = (a - 32'd1024) >> 2;
    return o[16:0];
  endfunction
  function automatic logic [31:0] ref_get(input logic [16:0] w);
    return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : 32'h0;
  endfunction
  always @(negedge clk) begin
    if (!sram_we_n) begin
      if (sb.size() == 0) chk("we_unexpected", {31'd0, sram_we_n}, 32'd1);
      else begin
        half = we_cnt >= W;
        chk("sram_addr", 32'(sram_addr), 32'({sb[0].word, half}));
        chk("sram_dq", 32'(sram_dq), 32'(half ? sb[0].wdata[31:16] : sb[0].wdata[15:0]));
      end
      we_cnt++;
    end
    if (rst) begin
      sb.delete();
      low = 0;
      we_cnt = 0;
    end else if (!ready) low++;
    else if (low > 0) begin
      if (sb.size() == 0) chk("done_unexpected", 32'(low), 32'd0);
      else begin
        cur = sb.pop_front();
        chk("stall_cycles", 32'(low), 32'(2 * W + 1));
        chk("we_cycles", 32'(we_cnt), cur.store ? 32'(2 * W) : 32'd0);
        chk("readData", read_data, cur.rd);
      end
      low = 0;
      we_cnt = 0;
    end
  end
  task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int n;
    e.store = w;
    e.word  = word_of(a);
    e.wdata = d;
    if (w) ref_mem[int'(e.word)] = d;
    else ref_rd = ref_get(e.word);
    e.rd = ref_rd;
    sb.push_back(e);
    mem_r_en = r; mem_w_en = w; address = a; write_data = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!ready && n < 50);
    if (!ready) chk("ready_timeout", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    mem_r_en = 0; mem_w_en = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] a;
    int k;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_readData", read_data, 32'd0);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("ties", {28'd0, ub_n, lb_n, ce_n, oe_n}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    idle(2);
    req(0, 1, 32'd1032, 32'hDEADBEEF);
    idle(1);
    chk("mem_lo", 32'(mem[4]), 32'h0000BEEF);
    chk("mem_hi", 32'(mem[5]), 32'h0000DEAD);
    req(1, 0, 32'd1032, 32'h0);
    idle(1);
    req(0, 1, 32'd1036, 32'h12345678);
    req(1, 0, 32'd1036, 32'h0);
    idle(1);
    req(1, 1, 32'd1028, 32'h0000AAAA);
    idle(1);
    // store aborted by reset while in HI: only the low half lands
    ref_mem[1] = {ref_get(17'd1) >> 16, 16'h6666};
    ref_rd = 0;
    sb.push_back('{store: 1'b1, word: 17'd1, wdata: 32'h55556666, rd: 32'h0});
    mem_w_en = 1; address = 32'd1028; write_data = 32'h55556666;
    repeat (W + 1) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_w_en = 0;
    @(negedge clk);
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_readData", read_data, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    req(1, 0, 32'd1028, 32'h0);
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 9) == 0) ? 32'd1020 : 32'd1024 + 4 * $urandom_range(0, 15);
      a = a + $urandom_range(0, 3);
      req(k < 4, k >= 4, a, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
    end
    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Data-memory responder for the pipeline's memory stage. Each EX request arrives through the EX/MEM register as an ALU result (byte address), store data (Rm value) and `MEM_R_EN`/`MEM_W_EN` strobes. The block serves it as two 16-bit accesses to an external asynchronous SRAM. While a request is in flight it deasserts `ready`, which the hazard logic uses as the pipeline freeze.

## Interface
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, 2: clock cycles spent on each 16-bit half access; legal range is 1..15.
- `clk` in 1: rising-edge clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `MEM_R_EN` in 1: load request from EX/MEM.
- `MEM_W_EN` in 1: store request from EX/MEM.
- `address` in 32: byte address (the ALU result).
- `writeData` in 32: store data (the Rm value).
- `readData` out 32: loaded word, registered.
- `ready` out 1: 1 when no request is pending or the request completes this cycle. 0 means freeze the pipeline.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_WE_N` out 1: write enable, active low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1 each: tied to 0.

## Operation
- States and transitions:
  - IDLE: request (`MEM_R_EN|MEM_W_EN`) → LO; otherwise stay in IDLE.
  - LO: low-halfword access.
  - HI: high-halfword access.
  - DONE: → IDLE unconditionally.
- Wait counter:
  - 4-bit `cnt` counts 0..WAIT_CYCLES-1 in LO and in HI.
  - LO→HI and HI→DONE occur when `cnt==WAIT_CYCLES-1`.
  - `cnt` clears on every state change.
- Address mapping:
  - `word = (address - BASE_ADDR) >> 2`, 32-bit subtraction with wrap.
  - `SRAM_ADDR = {word[16:0], half}`, where half=0 in IDLE/LO/DONE and half=1 in HI.
  - `address[1:0]` is ignored.
- Store:
  - LO: `SRAM_DQ=writeData[15:0]`, `SRAM_WE_N=0`.
  - HI: `SRAM_DQ=writeData[31:16]`, `SRAM_WE_N=0`.
  - All other states: `SRAM_WE_N=1` and `SRAM_DQ` high-Z.
- Load:
  - `SRAM_DQ` stays high-Z throughout, `SRAM_WE_N=1`.
  - On the last LO cycle (`cnt==WAIT_CYCLES-1`), register `readData[15:0] <= SRAM_DQ`.
  - On the last HI cycle, register `readData[31:16] <= SRAM_DQ`.
  - `readData` holds its value until the next load overwrites it; stores never modify it.
- Both strobes asserted: treated as a store; `readData` is unchanged.
- `ready = (state==IDLE && !MEM_R_EN && !MEM_W_EN) || state==DONE`, combinational.
- Inputs are held stable by the freeze while `ready=0`. The block samples `MEM_W_EN` and `writeData` combinationally in each state and does not latch them.

## Timing
- Reset state (applied at the first rising edge with `rst=1`):
  - state=IDLE, `cnt=0`, `readData=0`, `SRAM_WE_N=1`, `SRAM_DQ` high-Z.
  - `SRAM_ADDR = {word[16:0],1'b0}` of the current `address`.
  - `ready` follows the IDLE equation.
- Request first visible at cycle 0, with W=WAIT_CYCLES:
  - Cycle 0: IDLE, `ready=0`.
  - Cycles 1..W: LO.
  - Cycles W+1..2W: HI.
  - Cycle 2W+1: DONE, `ready=1`.
  - The pipeline advances on the edge that ends cycle 2W+1.
  - Stall is 2W+1 cycles; the default gives 5 stall cycles.
- Load data in `readData` is valid from cycle 2W+1 onward.
- Back-to-back requests: DONE→IDLE always takes one cycle. If the next request is already present in IDLE, `ready=0` again in that cycle and the sequence restarts.
- Reset mid-access: the next edge returns the block to IDLE and releases the bus. A partially written word stays partially written. `readData` clears to 0.
- Strobe dropped mid-access (illegal; freeze prevents it): the FSM still completes the sequence to DONE.

## Test plan
- Reset with no request → `ready=1`, `readData=0`, `SRAM_WE_N=1`, DQ high-Z, `SRAM_ADDR=0x00000` for address 1024.
- Store 0xDEADBEEF to address 1032 (W=2) → `SRAM_ADDR` is 0x00004 during LO with DQ=0xBEEF, then 0x00005 during HI with DQ=0xDEAD. `SRAM_WE_N=0` for 4 cycles in total. `ready` is 0 for 5 cycles, then 1 for one cycle.
- Load from address 1032 with an SRAM model preloaded → `readData=0xDEADBEEF` at DONE. `SRAM_WE_N` stays 1. `ready` low for exactly 5 cycles.
- Back-to-back: store 0x12345678 to 1036 followed immediately by a load from 1036 → two complete 6-cycle sequences separated by one IDLE cycle with `ready=0`. Load returns 0x12345678.
- Both strobes asserted with address 1028 and data 0x0000AAAA → performs a store; `readData` is unchanged.
- `rst` asserted during HI of a store → next cycle is IDLE with `SRAM_WE_N=1`, DQ high-Z, `readData=0`. A following load of that word returns the new low half and the old high half.
